// File: rtl/la_iopadctrl_pkg.sv
// la_iopadctrl_pkg: state encoding and stagger step count shared by la_iopadctrl
package la_iopadctrl_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, SEQ = 2'd1, ACTIVE = 2'd2} state_e;
  function automatic int num_steps(input int npins, input int group);
    return (npins + group - 1) / group;
  endfunction
endpackage

// File: rtl/la_iopadctrl_stagger.sv
// la_iopadctrl_stagger: delay/step counters releasing pins in groups of GROUP every STEPDLY cycles
module la_iopadctrl_stagger
  import la_iopadctrl_pkg::*;
#(
  parameter int NPINS   = 8,
  parameter int GROUP   = 4,
  parameter int STEPDLY = 16
) (
  input  logic             clk,
  input  logic             nreset,
  input  logic             start,
  input  logic             abort,
  output logic [NPINS-1:0] mask,
  output logic             done
);
  localparam int NSTEP = num_steps(NPINS, GROUP);
  localparam int CW = $clog2(STEPDLY + 1);
  localparam int SW = $clog2(NSTEP + 1);
  logic on_q, on_d, tick, last, adv;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [SW-1:0] step_q, step_d;
  logic [NPINS-1:0] mask_q, mask_d;
  always_comb begin
    tick = cnt_q == CW'(STEPDLY - 1);
    last = step_q == SW'(NSTEP - 1);
    adv = on_q & tick & ~last;
    on_d = start | (on_q & ~abort);
    step_d = (start | abort) ? '0 : adv ? step_q + 1'b1 : step_q;
    // counter holds at terminal count once the last group is out
    cnt_d = (start | abort | adv) ? '0 : (on_q & ~tick) ? cnt_q + 1'b1 : cnt_q;
  end
  for (genvar i = 0; i < NPINS; i++) begin : g_mask
    assign mask_d[i] = on_d & (SW'(i / GROUP) <= step_d);
  end
  always_ff @(posedge clk) begin
    if (!nreset) begin
      on_q <= 1'b0;
      cnt_q <= '0;
      step_q <= '0;
      mask_q <= '0;
    end else begin
      on_q <= on_d;
      cnt_q <= cnt_d;
      step_q <= step_d;
      mask_q <= mask_d;
    end
  end
  assign mask = mask_q;
  assign done = &mask_d;
endmodule

// File: rtl/la_iopadctrl.sv
// la_iopadctrl: per-pin ie/oe/cfg shadow registers with staggered power-up release of one padring side.
// Optional registered shadow readback port under LA_IOPADCTRL_READBACK_EN.
module la_iopadctrl
  import la_iopadctrl_pkg::*;
#(
  parameter int NPINS   = 8,
  parameter int CFGW    = 8,
  parameter int GROUP   = 4,
  parameter int STEPDLY = 16,
  parameter int AW      = (NPINS > 1) ? $clog2(NPINS) : 1
) (
  input  logic                  clk,
  input  logic                  nreset,
  input  logic                  en,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  input  logic [AW-1:0]         wr_addr,
  input  logic                  wr_ie,
  input  logic                  wr_oe,
  input  logic [CFGW-1:0]       wr_cfg,
`ifdef LA_IOPADCTRL_READBACK_EN
  input  logic [AW-1:0]         rd_addr,
  output logic                  rd_ie,
  output logic                  rd_oe,
  output logic [CFGW-1:0]       rd_cfg,
`endif
  output logic [NPINS-1:0]      ie,
  output logic [NPINS-1:0]      oe,
  output logic [NPINS*CFGW-1:0] cfg,
  output logic                  busy,
  output logic                  active,
  output logic                  err
);
  state_e state_q, state_d;
  logic [NPINS-1:0] sh_ie_q, sh_ie_d, sh_oe_q, sh_oe_d, ie_q, ie_d, oe_q, oe_d, mask;
  logic [NPINS*CFGW-1:0] sh_cfg_q, sh_cfg_d, cfg_q, cfg_d;
  logic err_q, err_d, we, hit, start, abort, done;
  assign wr_ready = state_q != SEQ;
  always_comb begin
    we = wr_valid & wr_ready;
    hit = 32'(wr_addr) < 32'(NPINS);
    sh_ie_d = sh_ie_q;
    sh_oe_d = sh_oe_q;
    sh_cfg_d = sh_cfg_q;
    if (we && hit) begin
      sh_ie_d[wr_addr] = wr_ie;
      sh_oe_d[wr_addr] = wr_oe;
      sh_cfg_d[32'(wr_addr)*CFGW +: CFGW] = wr_cfg;
    end
    err_d = err_q | (we & ~hit);
    start = (state_q == IDLE) & en;
    abort = (state_q != IDLE) & ~en;
    state_d = !en ? IDLE : (state_q == IDLE) ? SEQ : (state_q == SEQ && done) ? ACTIVE : state_q;
    // cfg is left ungated so it settles before the drivers are enabled
    ie_d = sh_ie_q & mask;
    oe_d = sh_oe_q & mask;
    cfg_d = sh_cfg_q;
  end
  la_iopadctrl_stagger #(
    .NPINS(NPINS),
    .GROUP(GROUP),
    .STEPDLY(STEPDLY)
  ) u_stagger (
    .clk(clk),
    .nreset(nreset),
    .start(start),
    .abort(abort),
    .mask(mask),
    .done(done)
  );
  always_ff @(posedge clk) begin
    if (!nreset) begin
      state_q <= IDLE;
      sh_ie_q <= '0;
      sh_oe_q <= '0;
      sh_cfg_q <= '0;
      err_q <= 1'b0;
      ie_q <= '0;
      oe_q <= '0;
      cfg_q <= '0;
    end else begin
      state_q <= state_d;
      sh_ie_q <= sh_ie_d;
      sh_oe_q <= sh_oe_d;
      sh_cfg_q <= sh_cfg_d;
      err_q <= err_d;
      ie_q <= ie_d;
      oe_q <= oe_d;
      cfg_q <= cfg_d;
    end
  end
  assign ie = ie_q;
  assign oe = oe_q;
  assign cfg = cfg_q;
  assign busy = state_q == SEQ;
  assign active = state_q == ACTIVE;
  assign err = err_q;
`ifdef LA_IOPADCTRL_READBACK_EN
  logic rd_hit, rd_ie_q, rd_ie_d, rd_oe_q, rd_oe_d;
  logic [CFGW-1:0] rd_cfg_q, rd_cfg_d;
  always_comb begin
    rd_hit = 32'(rd_addr) < 32'(NPINS);
    rd_ie_d = rd_hit ? sh_ie_q[rd_addr] : 1'b0;
    rd_oe_d = rd_hit ? sh_oe_q[rd_addr] : 1'b0;
    rd_cfg_d = rd_hit ? sh_cfg_q[32'(rd_addr)*CFGW +: CFGW] : '0;
  end
  always_ff @(posedge clk) begin
    if (!nreset) begin
      rd_ie_q <= 1'b0;
      rd_oe_q <= 1'b0;
      rd_cfg_q <= '0;
    end else begin
      rd_ie_q <= rd_ie_d;
      rd_oe_q <= rd_oe_d;
      rd_cfg_q <= rd_cfg_d;
    end
  end
  assign rd_ie = rd_ie_q;
  assign rd_oe = rd_oe_q;
  assign rd_cfg = rd_cfg_q;
`endif
endmodule

// File: tb/tb_la_iopadctrl.sv
// tb_la_iopadctrl: checks an 8-pin and a 10-pin instance against a release-count reference model
module tb_la_iopadctrl;
  localparam int G = 4;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic nreset;
  logic en[2], wv[2];
  logic [3:0] wad[2];
  logic wr_ie, wr_oe;
  logic [7:0] wr_cfg;
  logic [7:0] ie_a, oe_a;
  logic [63:0] cfg_a;
  logic rdy_a, busy_a, act_a, err_a;
  logic [9:0] ie_b, oe_b;
  logic [79:0] cfg_b;
  logic rdy_b, busy_b, act_b, err_b;
`ifdef LA_IOPADCTRL_READBACK_EN
  logic [2:0] rda_a;
  logic [3:0] rda_b;
  logic rie_a, roe_a, rie_b, roe_b;
  logic [7:0] rcfg_a, rcfg_b;
`endif
  la_iopadctrl #(.NPINS(8), .CFGW(8), .GROUP(G), .STEPDLY(16)) u_a (
    .clk(clk), .nreset(nreset), .en(en[0]), .wr_valid(wv[0]), .wr_ready(rdy_a),
    .wr_addr(wad[0][2:0]), .wr_ie(wr_ie), .wr_oe(wr_oe), .wr_cfg(wr_cfg),
`ifdef LA_IOPADCTRL_READBACK_EN
    .rd_addr(rda_a), .rd_ie(rie_a), .rd_oe(roe_a), .rd_cfg(rcfg_a),
`endif
    .ie(ie_a), .oe(oe_a), .cfg(cfg_a), .busy(busy_a), .active(act_a), .err(err_a)
  );
  la_iopadctrl #(.NPINS(10), .CFGW(8), .GROUP(G), .STEPDLY(3)) u_b (
    .clk(clk), .nreset(nreset), .en(en[1]), .wr_valid(wv[1]), .wr_ready(rdy_b),
    .wr_addr(wad[1]), .wr_ie(wr_ie), .wr_oe(wr_oe), .wr_cfg(wr_cfg),
`ifdef LA_IOPADCTRL_READBACK_EN
    .rd_addr(rda_b), .rd_ie(rie_b), .rd_oe(roe_b), .rd_cfg(rcfg_b),
`endif
    .ie(ie_b), .oe(oe_b), .cfg(cfg_b), .busy(busy_b), .active(act_b), .err(err_b)
  );
  int np[2] = '{8, 10};
  int sd[2] = '{16, 3};
  int m_st[2], m_t[2];
  logic [15:0] m_ie[2], m_oe[2], m_mask[2], x_ie[2], x_oe[2];
  logic [127:0] m_cfg[2], x_cfg[2];
  logic m_err[2];
  int checks = 0, failures = 0;

  // model: state 0 idle, 1 sequencing, 2 active; t counts edges since release began
  task automatic model_edge(input int k);
    int rel, ns, last_t;
    if (!nreset) begin
      m_st[k] = 0; m_t[k] = 0; m_ie[k] = '0; m_oe[k] = '0; m_cfg[k] = '0; m_mask[k] = '0;
      x_ie[k] = '0; x_oe[k] = '0; x_cfg[k] = '0; m_err[k] = 1'b0;
      return;
    end
    x_ie[k] = m_ie[k] & m_mask[k];
    x_oe[k] = m_oe[k] & m_mask[k];
    x_cfg[k] = m_cfg[k];
    if (wv[k] && m_st[k] != 1) begin
      if (int'(wad[k]) < np[k]) begin
        m_ie[k][wad[k]] = wr_ie;
        m_oe[k][wad[k]] = wr_oe;
        m_cfg[k][wad[k]*8 +: 8] = wr_cfg;
      end else m_err[k] = 1'b1;
    end
    ns = (np[k] + G - 1) / G;
    last_t = (ns > 1) ? (ns - 1) * sd[k] : 1;
    if (!en[k]) m_st[k] = 0;
    else if (m_st[k] == 0) begin m_st[k] = 1; m_t[k] = 0; end
    else if (m_st[k] == 1) begin m_t[k]++; if (m_t[k] >= last_t) m_st[k] = 2; end
    rel = (m_st[k] == 0) ? 0 : (m_st[k] == 2) ? np[k] : G * (1 + m_t[k] / sd[k]);
    if (rel > np[k]) rel = np[k];
    m_mask[k] = 16'((32'd1 << rel) - 1);
  endtask

  task automatic tick();
    model_edge(0);
    model_edge(1);
    @(posedge clk);
    #1;
  endtask

  function automatic logic [163:0] dut_vec(input int k);
    return (k == 0) ? {8'h0, ie_a, 8'h0, oe_a, 64'h0, cfg_a, rdy_a, busy_a, act_a, err_a}
                    : {6'h0, ie_b, 6'h0, oe_b, 48'h0, cfg_b, rdy_b, busy_b, act_b, err_b};
  endfunction
  function automatic logic [163:0] mdl_vec(input int k);
    return {x_ie[k], x_oe[k], x_cfg[k], m_st[k] != 1, m_st[k] == 1, m_st[k] == 2, m_err[k]};
  endfunction

  task automatic test_reset();
    nreset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      for (int k = 0; k < 2; k++) begin
        en[k] = 1'($urandom); wv[k] = 1'($urandom); wad[k] = 4'($urandom);
      end
      wr_ie = 1'($urandom); wr_oe = 1'($urandom); wr_cfg = 8'($urandom);
      tick();
    end
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (dut_vec(k) !== {160'h0, 4'b1000})
        begin failures++; $display("FAIL reset k=%0d got=%h exp=%h", k, dut_vec(k), {160'h0, 4'b1000}); end
    end
    for (int k = 0; k < 2; k++) begin en[k] = 0; wv[k] = 0; wad[k] = 0; end
    nreset = 1'b1;
    tick();
  endtask

  task automatic test_stagger();
    wr_ie = 1; wr_oe = 1; wr_cfg = 8'hA5;
    for (int p = 0; p < 8; p++) begin wv[0] = 1; wad[0] = 4'(p); tick(); end
    wv[0] = 0;
    tick();
    en[0] = 1;
    for (int c = 0; c < 20; c++) begin
      tick();
      checks++;
      if (dut_vec(0) !== mdl_vec(0))
        begin failures++; $display("FAIL stagger_model c=%0d got=%h exp=%h", c, dut_vec(0), mdl_vec(0)); end
      if (oe_a != 0) begin
        checks++;
        if (cfg_a !== {8{8'hA5}}) begin failures++; $display("FAIL stagger_cfg c=%0d got=%h exp=%h", c, cfg_a, {8{8'hA5}}); end
      end
      if (c == 1) begin
        checks++;
        if (oe_a !== 8'h0F || busy_a !== 1'b1) begin failures++; $display("FAIL stagger_first got oe=%h busy=%b exp oe=0f busy=1", oe_a, busy_a); end
      end
      if (c == 16) begin
        checks++;
        if (act_a !== 1'b1 || oe_a !== 8'h0F) begin failures++; $display("FAIL stagger_active got act=%b oe=%h exp act=1 oe=0f", act_a, oe_a); end
      end
      if (c == 17) begin
        checks++;
        if (oe_a !== 8'hFF || ie_a !== 8'hFF) begin failures++; $display("FAIL stagger_full got oe=%h ie=%h exp ff ff", oe_a, ie_a); end
      end
    end
  endtask

  task automatic test_abort();
    en[0] = 0;
    tick(); tick();
    checks++;
    if (oe_a !== 8'h0 || act_a !== 1'b0 || rdy_a !== 1'b1) begin failures++; $display("FAIL park got oe=%h act=%b rdy=%b exp 00 0 1", oe_a, act_a, rdy_a); end
    en[0] = 1;
    for (int c = 0; c < 5; c++) begin
      tick();
      checks++;
      if (dut_vec(0) !== mdl_vec(0)) begin failures++; $display("FAIL abort_model c=%0d got=%h exp=%h", c, dut_vec(0), mdl_vec(0)); end
    end
    en[0] = 0;
    tick();
    checks++;
    if (busy_a !== 1'b0 || rdy_a !== 1'b1) begin failures++; $display("FAIL abort_idle got busy=%b rdy=%b exp 0 1", busy_a, rdy_a); end
    tick();
    checks++;
    if (oe_a !== 8'h0 || ie_a !== 8'h0) begin failures++; $display("FAIL abort_gate got oe=%h ie=%h exp 00 00", oe_a, ie_a); end
    en[0] = 1;
    tick(); tick();
    checks++;
    if (oe_a !== 8'h0F) begin failures++; $display("FAIL abort_restart got oe=%h exp 0f", oe_a); end
  endtask

  task automatic test_write_active();
    int c = 0;
    wv[0] = 1; wad[0] = 4'd3; wr_oe = 0; wr_ie = 1; wr_cfg = 8'hA5;
    while (busy_a === 1'b1 && c < 30) begin
      checks++;
      if (rdy_a !== 1'b0) begin failures++; $display("FAIL hold_ready c=%0d got=%b exp=0", c, rdy_a); end
      tick();
      c++;
      checks++;
      if (dut_vec(0) !== mdl_vec(0)) begin failures++; $display("FAIL hold_model c=%0d got=%h exp=%h", c, dut_vec(0), mdl_vec(0)); end
    end
    checks++;
    if (c >= 30) begin failures++; $display("FAIL seq_timeout got busy after %0d cycles exp idle", c); end
    tick();
    wv[0] = 0;
    tick();
    checks++;
    if (oe_a !== 8'hF7 || act_a !== 1'b1) begin failures++; $display("FAIL write_active got oe=%h act=%b exp f7 1", oe_a, act_a); end
  endtask

  task automatic test_same_edge();
    en[0] = 0;
    tick(); tick();
    en[0] = 1; wv[0] = 1; wad[0] = 4'd0; wr_oe = 0; wr_ie = 1; wr_cfg = 8'h11;
    tick();
    wv[0] = 0;
    tick();
    checks++;
    if (oe_a !== 8'h06 || ie_a !== 8'h0F) begin failures++; $display("FAIL same_edge got oe=%h ie=%h exp 06 0f", oe_a, ie_a); end
    en[0] = 0;
    tick();
  endtask

  task automatic test_error();
    logic [79:0] prev;
    wr_ie = 1; wr_oe = 1; wr_cfg = 8'h3C; wv[1] = 1; wad[1] = 4'd9;
    tick();
    wv[1] = 0;
    tick();
    checks++;
    if (cfg_b[79:72] !== 8'h3C || err_b !== 1'b0) begin failures++; $display("FAIL err_inrange got cfg=%h err=%b exp 3c 0", cfg_b[79:72], err_b); end
    prev = cfg_b;
    wr_cfg = 8'hFF; wv[1] = 1; wad[1] = 4'd12;
    tick();
    wv[1] = 0;
    tick();
    checks++;
    if (err_b !== 1'b1 || cfg_b !== prev) begin failures++; $display("FAIL err_oob got err=%b cfg=%h exp 1 %h", err_b, cfg_b, prev); end
    for (int c = 0; c < 4; c++) begin
      wv[1] = 1; wad[1] = 4'(c); wr_cfg = 8'(c);
      tick();
      checks++;
      if (err_b !== 1'b1 || dut_vec(1) !== mdl_vec(1)) begin failures++; $display("FAIL err_sticky c=%0d got=%h exp=%h", c, dut_vec(1), mdl_vec(1)); end
    end
    wv[1] = 0;
  endtask

  task automatic test_partial();
    wr_ie = 1; wr_oe = 1; wr_cfg = 8'h5A;
    for (int p = 0; p < 10; p++) begin wv[1] = 1; wad[1] = 4'(p); tick(); end
    wv[1] = 0;
    en[1] = 1;
    for (int c = 0; c < 10; c++) begin
      tick();
      checks++;
      if (dut_vec(1) !== mdl_vec(1)) begin failures++; $display("FAIL partial_model c=%0d got=%h exp=%h", c, dut_vec(1), mdl_vec(1)); end
      if (c == 4) begin
        checks++;
        if (oe_b !== 10'h0FF) begin failures++; $display("FAIL partial_mid got oe=%h exp 0ff", oe_b); end
      end
      if (c == 7) begin
        checks++;
        if (oe_b !== 10'h3FF || act_b !== 1'b1) begin failures++; $display("FAIL partial_full got oe=%h act=%b exp 3ff 1", oe_b, act_b); end
      end
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      for (int k = 0; k < 2; k++) begin
        if ($urandom_range(0, 11) == 0) en[k] = ~en[k];
        wv[k] = 1'($urandom);
        wad[k] = (k == 0) ? 4'($urandom_range(0, 7)) : 4'($urandom_range(0, 15));
      end
      wr_ie = 1'($urandom); wr_oe = 1'($urandom); wr_cfg = 8'($urandom);
      tick();
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (dut_vec(k) !== mdl_vec(k)) begin failures++; $display("FAIL random c=%0d k=%0d got=%h exp=%h", c, k, dut_vec(k), mdl_vec(k)); end
      end
    end
    for (int k = 0; k < 2; k++) wv[k] = 0;
  endtask

  task automatic test_reset_mid_seq();
    en[0] = 0; en[1] = 0;
    tick();
    en[0] = 1; en[1] = 1;
    tick(); tick();
    nreset = 0;
    tick();
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (dut_vec(k) !== {160'h0, 4'b1000}) begin failures++; $display("FAIL reset_mid k=%0d got=%h exp=%h", k, dut_vec(k), {160'h0, 4'b1000}); end
    end
    nreset = 1; en[0] = 0; en[1] = 0;
    tick();
  endtask

`ifdef LA_IOPADCTRL_READBACK_EN
  task automatic test_readback();
    rda_a = 3'd2; rda_b = 4'd12;
    wv[0] = 1; wad[0] = 4'd2; wr_cfg = 8'h3C; wr_ie = 1; wr_oe = 0;
    tick();
    wv[0] = 0;
    tick();
    checks++;
    if (rcfg_a !== 8'h3C || rie_a !== 1'b1 || roe_a !== 1'b0) begin failures++; $display("FAIL readback got cfg=%h ie=%b oe=%b exp 3c 1 0", rcfg_a, rie_a, roe_a); end
    checks++;
    if (rcfg_b !== 8'h0 || rie_b !== 1'b0 || roe_b !== 1'b0) begin failures++; $display("FAIL readback_oob got cfg=%h ie=%b oe=%b exp 00 0 0", rcfg_b, rie_b, roe_b); end
  endtask
`endif

  initial begin
    nreset = 0; wr_ie = 0; wr_oe = 0; wr_cfg = 0;
    for (int k = 0; k < 2; k++) begin en[k] = 0; wv[k] = 0; wad[k] = 0; end
`ifdef LA_IOPADCTRL_READBACK_EN
    rda_a = 0; rda_b = 0;
`endif
    test_reset();
    test_stagger();
    test_abort();
    test_write_active();
    test_same_edge();
    test_error();
    test_partial();
    test_random();
    test_reset_mid_seq();
`ifdef LA_IOPADCTRL_READBACK_EN
    test_readback();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/la_iopadctrl.md
Name: la_iopadctrl

Overview:
- Configuration controller and power-up sequencer for one padring side (drives the ie/oe/cfg inputs of a side instance).
- Holds a shadow register per pin (ie, oe, cfg), written through a valid/ready write port.
- On enable, releases pins in staggered groups so output drivers do not all turn on in the same cycle (limits simultaneous-switching noise on vddio/vssio sections).
- Sits between the core register bus and the padring side inputs.

Parameters:
- NPINS, 8, pins controlled (>=1)
- CFGW, 8, config bits per pin
- GROUP, 4, pins released per stagger step (1..NPINS)
- STEPDLY, 16, clock cycles between stagger steps (>=1)
- AW, $clog2(NPINS) (min 1), write address width

Ports:
- clk  input  1  clock
- nreset  input  1  synchronous active-low reset
- en  input  1  level; 1 = release pads, 0 = park pads
- wr_valid  input  1  write request
- wr_ready  output  1  write accepted when wr_valid & wr_ready
- wr_addr  input  AW  pin index
- wr_ie  input  1  input enable value
- wr_oe  input  1  output enable value
- wr_cfg  input  CFGW  config value
- ie  output  NPINS  to padring side
- oe  output  NPINS  to padring side
- cfg  output  NPINS*CFGW  to padring side; pin i at [i*CFGW +: CFGW]
- busy  output  1  1 while in state SEQ
- active  output  1  1 while in state ACTIVE
- err  output  1  sticky; set by an out-of-range write

Behaviour:
- One clock (clk). Reset is synchronous and active-low (nreset sampled on the clk rising edge).
- Reset values:
  - all shadow ie/oe/cfg bits = 0; release mask = 0
  - ie = oe = cfg = 0
  - busy = active = err = 0; wr_ready = 1; state = IDLE
- Outputs are registered:
  - ie[i] = shadow_ie[i] & mask[i]; oe[i] = shadow_oe[i] & mask[i]
  - cfg = shadow cfg, ungated, so config settles before release
- Writes:
  - Accepted on wr_valid & wr_ready.
  - The shadow register updates at the accepting edge; the outputs reflect it one cycle later.
  - wr_ready = 0 in SEQ, 1 in IDLE and ACTIVE.
  - wr_addr >= NPINS: the write is accepted but ignored, and err is set (cleared only by reset).
- States:
  - IDLE: mask = 0.
    - en = 1 -> SEQ; step counter = 0, first group is unmasked on the same edge.
  - SEQ: every STEPDLY cycles, unmask the next GROUP pins in ascending index order.
    - The final group may be partial (NPINS not a multiple of GROUP).
    - When mask reaches all-ones -> ACTIVE.
    - en = 0 at any point in SEQ -> IDLE; mask cleared at the same edge.
  - ACTIVE: mask = all-ones; writes take effect immediately.
    - en = 0 -> IDLE; mask cleared at the same edge.
- Timing: the last group is released ceil(NPINS/GROUP)-1 steps after the first, i.e. (ceil(NPINS/GROUP)-1)*STEPDLY cycles after IDLE->SEQ.
  - ACTIVE is asserted on the same edge the mask completes.
- Special cases:
  - NPINS <= GROUP: IDLE -> SEQ -> ACTIVE on the next edge.
  - Same-edge wr_valid and en rise in IDLE: the write is accepted (wr_ready = 1) and lands in the shadow before its pin is released.
  - nreset low mid-SEQ: all state returns to reset values on that edge.
- The delay counter is $clog2(STEPDLY+1) bits and saturates at terminal count; there is no wrap in SEQ.

Optional Feature:
- Macro: LA_IOPADCTRL_READBACK_EN.
- Defined: adds ports rd_addr (input, AW), rd_ie, rd_oe (output, 1), rd_cfg (output, CFGW).
  - Registered readback of the shadow (not gated) values, one-cycle latency.
  - Out-of-range rd_addr returns 0.
- Undefined: these ports are absent and there is no readback logic.

Decomposition:
- Package la_iopadctrl_pkg:
  - state encoding constants IDLE = 2'd0, SEQ = 2'd1, ACTIVE = 2'd2
  - function to compute the number of steps, ceil(NPINS/GROUP)
- Sub-module la_iopadctrl_stagger:
  - contains the delay counter, step counter and mask generation
  - inputs: start, abort; outputs: mask[NPINS], done
- Top level keeps the shadow registers, the write port, the FSM and the output gating.

Test Plan:
- Reset: hold nreset = 0 for 3 cycles with random inputs -> ie = oe = cfg = 0, wr_ready = 1, busy = active = err = 0.
- Stagger (NPINS=8, GROUP=4, STEPDLY=16):
  - stimulus: write oe = 1, ie = 1, cfg = 8'hA5 to all pins, then raise en
  - next cycle: oe = 8'h0F
  - 16 cycles later: oe = 8'hFF, active = 1
  - cfg = 8'hA5 for every pin before any oe bit rises
- Abort: drop en 5 cycles into SEQ -> next cycle oe = ie = 0, state IDLE, wr_ready = 1; re-raise en -> the sequence restarts from pin 0.
- Write in ACTIVE: write pin 3 with oe = 0 -> oe = 8'hF7 two edges after the write is issued; a wr_valid held during SEQ is not accepted until SEQ ends.
- Error: write wr_addr = 9 with NPINS = 10 accepted; then wr_addr = 12 with NPINS = 10 -> no shadow change, err = 1 and stays set until reset.
- Readback (with LA_IOPADCTRL_READBACK_EN defined): rd_addr = 2 after writing cfg = 8'h3C -> rd_cfg = 8'h3C one cycle later, including while in IDLE.
